// File: rtl/bram_rd_stream.sv
// bram_rd_stream: turns a valid/ready address stream into single-cycle BRAM
// reads and returns the data through a credit-controlled response FIFO.
module bram_rd_stream #(
  parameter int ADDR_WIDTH    = 4,
  parameter int ELEMENT_WIDTH = 16,
  parameter int DEPTH         = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     mem_addr_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr_data,
  output logic                     mem_rd_en,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ELEMENT_WIDTH-1:0] resp_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0]            r_occ;
  logic [CW-1:0]            w_occ_next;
  logic [CW-1:0]            w_count;
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [PW-1:0]            w_wptr_next;
  logic [PW-1:0]            w_rptr_next;
  logic [PW-1:0]            w_wptr_inc;
  logic [PW-1:0]            w_rptr_inc;
  logic                     r_inflight;
  logic                     r_drop;
  logic                     r_resp_valid;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic [ELEMENT_WIDTH-1:0] r_fifo [DEPTH];

  // Credits cover both buffered data and the read still in the BRAM pipeline,
  // so acceptance never depends on resp_ready in the same cycle.
  assign w_count   = r_occ + CW'(r_inflight);
  assign req_ready = rst & ~flush & (w_count < CW'(DEPTH));
  assign w_issue   = req_valid & req_ready;

  assign mem_addr_en   = w_issue;
  assign mem_rd_en     = w_issue;
  assign mem_addr_data = req_addr;

  assign w_pop  = r_resp_valid & resp_ready;
  assign w_push = r_inflight & ~r_drop & ~flush;

  assign w_wptr_inc = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
  assign w_rptr_inc = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

  always_comb begin
    w_occ_next  = r_occ;
    w_wptr_next = r_wptr;
    w_rptr_next = r_rptr;
    if (w_pop) begin
      w_rptr_next = w_rptr_inc;
    end
    if (w_push) begin
      w_wptr_next = w_wptr_inc;
    end
    if (w_push && !w_pop) begin
      w_occ_next = r_occ + CW'(1);
    end else if (!w_push && w_pop) begin
      w_occ_next = r_occ - CW'(1);
    end
    // Flush empties the FIFO after honouring any pop made in the same cycle.
    if (flush) begin
      w_occ_next  = '0;
      w_wptr_next = w_rptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ        <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_inflight   <= 1'b0;
      r_drop       <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_occ        <= w_occ_next;
      r_wptr       <= w_wptr_next;
      r_rptr       <= w_rptr_next;
      r_inflight   <= w_issue;
      r_drop       <= flush & r_inflight;
      r_resp_valid <= (w_occ_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= mem_rd_data;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_valid ? r_fifo[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_push && (r_occ == CW'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_bram_rd_stream.sv
// Testbench for bram_rd_stream: BRAM model plus scoreboard on a DEPTH=3 and
// a DEPTH=2 instance driven with directed request sequences.
module tb_bram_rd_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic        mem_addr_en;
  logic [3:0]  mem_addr_data;
  logic        mem_rd_en;
  logic [15:0] mem_rd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;

  logic        flush2;
  logic        req2_valid;
  logic        req2_ready;
  logic [3:0]  req2_addr;
  logic        mem2_addr_en;
  logic [3:0]  mem2_addr_data;
  logic        mem2_rd_en;
  logic [15:0] mem2_rd_data;
  logic        resp2_valid;
  logic        resp2_ready;
  logic [15:0] resp2_data;

  logic [15:0] bram [16];
  logic [15:0] exp_q  [$];
  logic [15:0] exp2_q [$];
  logic [15:0] e1;
  logic [15:0] e2;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_resp2  = 0;

  bram_rd_stream #(.ADDR_WIDTH(4), .ELEMENT_WIDTH(16), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .mem_addr_en(mem_addr_en), .mem_addr_data(mem_addr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  bram_rd_stream #(.ADDR_WIDTH(4), .ELEMENT_WIDTH(16), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .req_valid(req2_valid), .req_ready(req2_ready), .req_addr(req2_addr),
    .mem_addr_en(mem2_addr_en), .mem_addr_data(mem2_addr_data),
    .mem_rd_en(mem2_rd_en), .mem_rd_data(mem2_rd_data),
    .resp_valid(resp2_valid), .resp_ready(resp2_ready), .resp_data(resp2_data)
  );

  // One-cycle-latency BRAM; output is scrambled when not read so stray
  // sampling of mem_rd_data shows up as wrong data.
  always @(posedge clk) begin
    if (mem_addr_en && mem_rd_en) mem_rd_data <= bram[mem_addr_data];
    else                          mem_rd_data <= 16'($urandom);
    if (mem2_addr_en && mem2_rd_en) mem2_rd_data <= bram[mem2_addr_data];
    else                            mem2_rd_data <= 16'($urandom);
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL resp_unexpected got=%h expected=none", resp_data);
        end else begin
          e1 = exp_q.pop_front();
          if (resp_data !== e1) begin
            n_errors++;
            $display("FAIL resp_data got=%h expected=%h", resp_data, e1);
          end else begin
            $display("resp  data=%h", resp_data);
          end
        end
      end
      if (req_valid && req_ready) exp_q.push_back(bram[req_addr]);
      if (flush) exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp2_q.delete();
    end else begin
      if (resp2_valid && resp2_ready) begin
        n_checks++;
        n_resp2++;
        if (exp2_q.size() == 0) begin
          n_errors++;
          $display("FAIL resp2_unexpected got=%h expected=none", resp2_data);
        end else begin
          e2 = exp2_q.pop_front();
          if (resp2_data !== e2) begin
            n_errors++;
            $display("FAIL resp2_data got=%h expected=%h", resp2_data, e2);
          end else begin
            $display("resp2 data=%h", resp2_data);
          end
        end
      end
      if (req2_valid && req2_ready) exp2_q.push_back(bram[req2_addr]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic load_three();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 req_valid = 1'b1; req_addr = 4'(7 + i);
    end
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  initial begin
    logic [19:0] vhist;
    int          acc;
    int          a2;
    int          c0;
    int          c1;

    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    flush2 = 1'b0; req2_valid = 1'b0; req2_addr = '0; resp2_ready = 1'b0;
    for (int i = 0; i < 16; i++) bram[i] = 16'(i * 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_req_ready", {31'd0, req_ready}, 0);
    check("rst_mem_rd_en", {31'd0, mem_rd_en}, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 1);

    // Streaming: 16 back-to-back reads with no backpressure.
    resp_ready = 1'b1;
    vhist = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 req_valid = (i < 16); req_addr = 4'(i);
      @(negedge clk);
      vhist[i] = resp_valid;
      if (i < 16) check("stream_req_ready", {31'd0, req_ready}, 1);
    end
    check("stream_valid_run", {12'd0, vhist}, 32'h3FFFC);

    // Single read: issue visible in the accept cycle, data two cycles later.
    bram[5] = 16'hBEEF;
    @(posedge clk); #1 req_valid = 1'b1; req_addr = 4'd5;
    @(negedge clk);
    check("single_addr_en", {31'd0, mem_addr_en}, 1);
    check("single_addr", {28'd0, mem_addr_data}, 5);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("single_no_bypass", {31'd0, resp_valid}, 0);
    @(negedge clk);
    check("single_resp_valid", {31'd0, resp_valid}, 1);
    check("single_resp_data", {16'd0, resp_data}, 32'hBEEF);
    @(posedge clk); #1 bram[5] = 16'd15;

    // Backpressure: credits stop acceptance at DEPTH.
    resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 req_valid = 1'b1; req_addr = 4'(acc);
      @(negedge clk);
      if (req_ready) acc++;
    end
    check("bp_accepts", 32'(acc), 3);
    check("bp_req_ready", {31'd0, req_ready}, 0);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    check("bp_no_comb_ready", {31'd0, req_ready}, 0);
    @(negedge clk);
    check("bp_resume", {31'd0, req_ready}, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    check("bp_drained", 32'(exp_q.size()), 0);

    // Flush with two buffered and one in flight.
    load_three();
    flush = 1'b1;
    @(negedge clk);
    check("flush_req_ready", {31'd0, req_ready}, 0);
    @(posedge clk); #1 flush = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    check("flush_resp_valid", {31'd0, resp_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_no_stale", {31'd0, resp_valid}, 0);
    end
    @(posedge clk); #1 req_valid = 1'b1; req_addr = 4'd10;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    check("flush_next_drained", 32'(exp_q.size()), 0);

    // DEPTH=2 instance: two responses per three cycles in steady state.
    resp2_ready = 1'b1;
    a2 = 0;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (i == 10) c0 = n_resp2;
      if (i == 28) c1 = n_resp2;
      #1 req2_valid = 1'b1; req2_addr = 4'(a2);
      @(negedge clk);
      if (req2_ready) a2 = (a2 + 1) % 16;
    end
    check("d2_throughput", 32'(c1 - c0), 12);
    @(posedge clk); #1 req2_valid = 1'b0;
    repeat (6) @(posedge clk);
    check("d2_drained", 32'(exp2_q.size()), 0);

    // Reset mid-operation with two buffered and one in flight.
    load_three();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", {31'd0, resp_valid}, 0);
    check("midrst_resp_data", {16'd0, resp_data}, 0);
    check("midrst_req_ready", {31'd0, req_ready}, 0);
    @(posedge clk); #1 rst = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", {31'd0, req_ready}, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_stale", {31'd0, resp_valid}, 0);
    end
    @(posedge clk); #1 req_valid = 1'b1; req_addr = 4'd12;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    check("final_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_rd_stream.md
Name: bram_rd_stream

Overview:
- Converts a valid/ready address-request stream into BRAM read-port transactions and returns read data as a valid/ready response stream.
- Drives the read port of the single-cycle-latency read-first BRAM wrapper (p0_addr_en / p0_addr_data / p0_rd_en in, p0_rd_data out).
- Absorbs downstream backpressure with a credit-controlled response FIFO, so no read datum is lost while the consumer stalls.
- Sits between HIR-generated load logic and the memory primitive.

Parameters:
- ADDR_WIDTH, 4, width of the request address and memory address bus.
- ELEMENT_WIDTH, 16, width of the read data.
- DEPTH, 3, response FIFO entries. Legal range is DEPTH >= 2. DEPTH >= 3 gives one response per cycle.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- flush  input  1  synchronous discard of buffered and in-flight reads.
- req_valid  input  1  request address valid.
- req_ready  output  1  block can accept a request this cycle.
- req_addr  input  ADDR_WIDTH  read address.
- mem_addr_en  output  1  to BRAM read-port address enable.
- mem_addr_data  output  ADDR_WIDTH  to BRAM read-port address.
- mem_rd_en  output  1  to BRAM read-port read enable.
- mem_rd_data  input  ELEMENT_WIDTH  from BRAM read data, valid one cycle after issue.
- resp_valid  output  1  response data valid.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  ELEMENT_WIDTH  response data (FIFO head).

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO occupancy, read/write pointers, in-flight flag and drop flag clear to 0.
  - resp_valid=0, resp_data=0.
  - req_ready, mem_addr_en and mem_rd_en are forced to 0 while rst=0.
- Credit and request acceptance:
  - count = occupancy + inflight, where inflight is 0 or 1.
  - req_ready = rst & ~flush & (count < DEPTH).
  - req_ready has no combinational path from resp_ready.
- Issue:
  - In a cycle N where req_valid & req_ready: mem_addr_en = mem_rd_en = 1 and mem_addr_data = req_addr, all combinational.
  - Otherwise mem_addr_en = mem_rd_en = 0 and mem_addr_data = req_addr (don't-care).
  - inflight is set at the end of cycle N.
- Capture:
  - In cycle N+1, inflight=1 and mem_rd_data holds the BRAM output.
  - The datum is pushed at FIFO tail at the end of N+1 and inflight clears, unless a new issue in N+1 sets it again.
  - mem_rd_data is sampled only in capture cycles, never otherwise.
- Response:
  - resp_valid = (occupancy != 0), registered.
  - resp_data = FIFO head.
  - A pop occurs when resp_valid & resp_ready.
  - Request-to-response latency: accept in N gives resp_valid in N+2 at the earliest. There is no bypass path, even into an empty FIFO.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- Overflow cannot occur because of the credit rule. A push when occupancy == DEPTH is an assertion failure.
- Throughput:
  - DEPTH >= 3 with resp_ready held high: one accept and one response every cycle.
  - DEPTH == 2: at most 2 responses per 3 cycles.
- Ordering: responses return strictly in request order.
- Flush (synchronous, flush=1 in cycle F):
  - No issue in F.
  - FIFO is emptied at the end of F; resp_valid=0 in F+1.
  - A pop in F is still permitted (the head is consumed normally).
  - If inflight=1 in F, that capture in F+1 is discarded: the drop flag is set at the end of F and cleared after F+1.
  - Issues resume in F+1 if flush=0.
- Reset mid-operation:
  - All state is lost immediately.
  - A BRAM read in flight is ignored after rst returns to 1, because inflight=0.
- Pop when empty: ignored (resp_ready with resp_valid=0 has no effect).
- Arithmetic: occupancy and count are $clog2(DEPTH+1) bits. No other arithmetic.

Test Plan:
- Reset:
  - Stimulus: drive rst=0 mid-stream with 2 entries buffered and 1 in flight, then release.
  - Required: resp_valid=0 and req_ready=0 during reset; req_ready=1 the first cycle after; no stale data ever emerges.
- Single read:
  - Stimulus: preload BRAM addr 5 = 0xBEEF; accept addr 5 in cycle 10.
  - Required: mem_addr_en=1 and mem_addr_data=5 in cycle 10; resp_valid=1 and resp_data=0xBEEF in cycle 12.
- Streaming:
  - Stimulus: DEPTH=3, resp_ready=1, 16 back-to-back requests for addrs 0..15 holding value addr*3.
  - Required: 16 consecutive resp_valid cycles with data 0,3,...,45 in order; req_ready never deasserts.
- Backpressure:
  - Stimulus: resp_ready=0 with continuous requests.
  - Required: exactly 3 requests accepted, then req_ready=0. After resp_ready=1, the 3 responses emerge in order and accepts resume.
- Flush with read in flight:
  - Stimulus: occupancy=2, inflight=1, assert flush for 1 cycle.
  - Required: resp_valid=0 next cycle; the in-flight datum is never presented; the next request after the flush returns its own correct data.
- DEPTH=2 throughput:
  - Stimulus: continuous requests with resp_ready=1.
  - Required: steady state of 2 responses per 3 cycles; no loss or reordering.
